// File: rtl/minmax_pkg.sv
// Shared constants and tree-sizing helpers for the min_max selector.
// Optional pipelining is controlled by the MINMAX_PIPE_EN macro.
package minmax_pkg;

   localparam int MM_BOTH     = 0;
   localparam int MM_MIN      = 1;
   localparam int MM_MAX      = 2;

   localparam int OUT_VAL_IDX = 0;
   localparam int OUT_VAL     = 1;

   // Number of levels needed to reduce ni operands to one.
   function automatic int tree_depth(input int ni);
      int n;
      int d;
      n = ni;
      d = 0;
      while (n > 1) begin
         n = (n + 1) / 2;
         d++;
      end
      return d;
   endfunction

   // Number of live entries entering tree level lvl.
   function automatic int tree_cnt(input int ni, input int lvl);
      int n;
      n = ni;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

endpackage

// File: rtl/minmax_node.sv
// Single two-input unsigned compare node of the min/max tree.
// The lower-index input wins ties; mode 0 = min, 1 = max.
module minmax_node #(
   parameter int W    = 8,
   parameter int IDXW = 4
) (
   input  logic            mode,
   input  logic [W-1:0]    a_val,
   input  logic [IDXW-1:0] a_idx,
   input  logic [W-1:0]    b_val,
   input  logic [IDXW-1:0] b_idx,
   output logic [W-1:0]    val,
   output logic [IDXW-1:0] idx
);

   logic b_win;

   // b only displaces a on a strict improvement
   always_comb begin
      b_win = mode ? (b_val > a_val) : (b_val < a_val);
      val   = b_win ? b_val : a_val;
      idx   = b_win ? b_idx : a_idx;
   end

endmodule

// File: rtl/min_max.sv
// Unsigned arg-min/arg-max over NI operands via a binary compare tree.
// Define MINMAX_PIPE_EN to register every tree level (latency = depth).
module min_max
   import minmax_pkg::*;
#(
   parameter int W       = 8,
   parameter int NI      = 9,
   parameter int IDXW    = $clog2(NI),
   parameter int OUT_CFG = OUT_VAL_IDX,
   parameter int MM_CFG  = MM_BOTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [W-1:0]    x [NI],
   input  logic            min_max_sel,
   output logic            out_valid,
   output logic [W-1:0]    result,
   output logic [IDXW-1:0] index
);

   localparam int L = tree_depth(NI);

   if (MM_CFG > MM_MAX || MM_CFG < MM_BOTH) begin : g_bad_cfg
      $error("min_max: MM_CFG must be 0, 1 or 2");
   end

   logic mode_in;

   assign mode_in = (MM_CFG == MM_MIN) ? 1'b0 :
                    (MM_CFG == MM_MAX) ? 1'b1 : min_max_sel;

   for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int NIN  = tree_cnt(NI, l);
      localparam int NOUT = tree_cnt(NI, l + 1);
`ifdef MINMAX_PIPE_EN
      localparam bit REG = 1'b1;
`else
      localparam bit REG = (l == L - 1);
`endif

      logic [W-1:0]    i_val [NI];
      logic [IDXW-1:0] i_idx [NI];
      logic            i_mode;
      logic            i_vld;

      logic [W-1:0]    c_val [NI];
      logic [IDXW-1:0] c_idx [NI];

      logic [W-1:0]    o_val [NI];
      logic [IDXW-1:0] o_idx [NI];
      logic            o_mode;
      logic            o_vld;

      if (l == 0) begin : g_src
         assign i_vld  = in_valid;
         assign i_mode = mode_in;
         for (genvar j = 0; j < NI; j++) begin : g_in
            assign i_val[j] = x[j];
            if (OUT_CFG == OUT_VAL) begin : g_noidx
               assign i_idx[j] = '0;
            end else begin : g_idx
               assign i_idx[j] = IDXW'(j);
            end
         end
      end else begin : g_src
         assign i_vld  = g_lvl[l-1].o_vld;
         assign i_mode = g_lvl[l-1].o_mode;
         assign i_val  = g_lvl[l-1].o_val;
         assign i_idx  = g_lvl[l-1].o_idx;
      end

      for (genvar j = 0; j < NI; j++) begin : g_n
         if (j < NOUT && 2 * j + 1 < NIN) begin : g_cmp
            minmax_node #(
               .W    (W),
               .IDXW (IDXW)
            ) u_node (
               .mode  (i_mode),
               .a_val (i_val[2*j]),
               .a_idx (i_idx[2*j]),
               .b_val (i_val[2*j+1]),
               .b_idx (i_idx[2*j+1]),
               .val   (c_val[j]),
               .idx   (c_idx[j])
            );
         end else if (j < NOUT) begin : g_pass
            assign c_val[j] = i_val[2*j];
            assign c_idx[j] = i_idx[2*j];
         end else begin : g_zero
            assign c_val[j] = '0;
            assign c_idx[j] = '0;
         end
      end

      if (REG) begin : g_reg
         // Stage register; data only advances with a valid sample
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               o_vld  <= 1'b0;
               o_mode <= 1'b0;
               for (int j = 0; j < NI; j++) begin
                  o_val[j] <= '0;
                  o_idx[j] <= '0;
               end
            end else begin
               o_vld <= i_vld;
               if (i_vld) begin
                  o_mode <= i_mode;
                  for (int j = 0; j < NI; j++) begin
                     o_val[j] <= c_val[j];
                     o_idx[j] <= c_idx[j];
                  end
               end
            end
         end
      end else begin : g_comb
         assign o_vld  = i_vld;
         assign o_mode = i_mode;
         assign o_val  = c_val;
         assign o_idx  = c_idx;
      end
   end

   assign out_valid = g_lvl[L-1].o_vld;
   assign result    = g_lvl[L-1].o_val[0];

   if (OUT_CFG == OUT_VAL) begin : g_out_val
      assign index = '0;
   end else begin : g_out_idx
      assign index = g_lvl[L-1].o_idx[0];
   end

endmodule

// File: tb/tb_min_max.sv
// Self-checking bench for min_max: default, forced-max/value-only
// and NI=2 instances against a first-occurrence arg-min/max model.
module tb_min_max;

`ifdef MINMAX_PIPE_EN
   localparam int LAT9 = 4;
   localparam int LAT2 = 1;
`else
   localparam int LAT9 = 1;
   localparam int LAT2 = 1;
`endif

   typedef struct {
      int         due;
      logic [7:0] res;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] x [9];
   logic [7:0] x2 [2];

   logic       v_a, v_f, v_t;
   logic [7:0] r_a, r_f, r_t;
   logic [3:0] i_a, i_f;
   logic [0:0] i_t;

   exp_t q_a[$], q_f[$], q_t[$];
   logic [7:0] h_ra, h_rf, h_rt;
   int         h_ia, h_if, h_it;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   min_max u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .min_max_sel(sel), .out_valid(v_a), .result(r_a), .index(i_a)
   );

   min_max #(.OUT_CFG(1), .MM_CFG(2)) u_f (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .min_max_sel(sel), .out_valid(v_f), .result(r_f), .index(i_f)
   );

   min_max #(.NI(2)) u_t (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x2),
      .min_max_sel(sel), .out_valid(v_t), .result(r_t), .index(i_t)
   );

   always #5 clk = ~clk;

   function automatic void ref_mm(input logic [7:0] v [9], input int n,
                                  input bit mx, output logic [7:0] r,
                                  output int k);
      r = v[0];
      k = 0;
      for (int i = 1; i < n; i++)
         if (mx ? (v[i] > r) : (v[i] < r)) begin
            r = v[i];
            k = i;
         end
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit v, input bit s);
      exp_t e;
      in_valid = v;
      sel      = s;
      x2[0]    = x[0];
      x2[1]    = x[1];
      if (v) begin
         e.due = cyc + LAT9;
         ref_mm(x, 9, s, e.res, e.idx);
         q_a.push_back(e);
         ref_mm(x, 9, 1'b1, e.res, e.idx);
         e.idx = 0;
         q_f.push_back(e);
         e.due = cyc + LAT2;
         ref_mm(x, 2, s, e.res, e.idx);
         q_t.push_back(e);
      end
   endtask

   task automatic step();
      exp_t e;
      logic ev;
      @(posedge clk);
      cyc++;
      #1;
      ev = 1'b0;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
         e = q_a.pop_front(); ev = 1'b1; h_ra = e.res; h_ia = e.idx;
      end
      chk("a_vld", 32'(v_a), 32'(ev));
      chk("a_res", 32'(r_a), 32'(h_ra));
      chk("a_idx", 32'(i_a), 32'(h_ia));
      ev = 1'b0;
      if (q_f.size() > 0 && q_f[0].due == cyc) begin
         e = q_f.pop_front(); ev = 1'b1; h_rf = e.res; h_if = e.idx;
      end
      chk("f_vld", 32'(v_f), 32'(ev));
      chk("f_res", 32'(r_f), 32'(h_rf));
      chk("f_idx", 32'(i_f), 32'(h_if));
      ev = 1'b0;
      if (q_t.size() > 0 && q_t[0].due == cyc) begin
         e = q_t.pop_front(); ev = 1'b1; h_rt = e.res; h_it = e.idx;
      end
      chk("t_vld", 32'(v_t), 32'(ev));
      chk("t_res", 32'(r_t), 32'(h_rt));
      chk("t_idx", 32'(i_t), 32'(h_it));
   endtask

   task automatic send(input bit s);
      drive(1'b1, s);
      step();
      in_valid = 1'b0;
      repeat (LAT9 - 1) step();
   endtask

   task automatic zero_all();
      chk("rst_a_vld", 32'(v_a), 0);
      chk("rst_a_res", 32'(r_a), 0);
      chk("rst_a_idx", 32'(i_a), 0);
      chk("rst_f_vld", 32'(v_f), 0);
      chk("rst_t_vld", 32'(v_t), 0);
      chk("rst_t_res", 32'(r_t), 0);
   endtask

   initial begin
      h_ra = 0; h_rf = 0; h_rt = 0;
      h_ia = 0; h_if = 0; h_it = 0;
      foreach (x[i]) x[i] = 8'd0;
      x2[0] = 8'd0;
      x2[1] = 8'd0;
      #3;
      zero_all();
      step();
      step();
      rst_n = 1'b1;
      step();

      x = '{8'd7, 8'd3, 8'd9, 8'd3, 8'd200, 8'd0, 8'd0, 8'd12, 8'd255};
      send(1'b0);
      chk("v1_min_res", 32'(r_a), 0);
      chk("v1_min_idx", 32'(i_a), 5);
      chk("v1_fix_res", 32'(r_f), 255);
      send(1'b1);
      chk("v1_max_res", 32'(r_a), 255);
      chk("v1_max_idx", 32'(i_a), 8);

      foreach (x[i]) x[i] = 8'hFF;
      send(1'b0);
      chk("ff_min_res", 32'(r_a), 255);
      chk("ff_min_idx", 32'(i_a), 0);
      send(1'b1);
      chk("ff_max_idx", 32'(i_a), 0);

      foreach (x[i]) x[i] = 8'd0;
      send(1'b1);
      chk("z_res", 32'(r_a), 0);
      chk("z_idx", 32'(i_a), 0);

      foreach (x[i]) x[i] = 8'(i + 1);
      send(1'b0);
      chk("seq_fix_res", 32'(r_f), 9);
      chk("seq_fix_idx", 32'(i_f), 0);
      chk("seq_min_res", 32'(r_a), 1);

      for (int n = 0; n < 1200; n++) begin
         foreach (x[i])
            x[i] = ($urandom % 4 == 0) ? 8'($urandom_range(0, 3))
                                       : 8'($urandom);
         if (n < 1000) drive(1'b1, n[0]);
         else          drive(($urandom % 8) != 0, 1'($urandom));
         step();
      end
      in_valid = 1'b0;
      repeat (LAT9 + 1) step();

      foreach (x[i]) x[i] = 8'($urandom);
      drive(1'b1, 1'b1);
      step();
      foreach (x[i]) x[i] = 8'($urandom);
      drive(1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      zero_all();
      in_valid = 1'b0;
      q_a.delete(); q_f.delete(); q_t.delete();
      h_ra = 0; h_rf = 0; h_rt = 0;
      h_ia = 0; h_if = 0; h_it = 0;
      step();
      rst_n = 1'b1;
      repeat (LAT9 + 2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
